// File: rtl/stream_uart_tx.sv
// Byte-stream (valid/ready) to 8N1 UART transmitter.
// Can optionally append a 0x0A newline frame after each byte marked with tlast.
module stream_uart_tx #(
    parameter int unsigned CLK_FREQ_HZ  = 16000000,
    parameter int unsigned BAUD_RATE    = 57600,
    parameter int unsigned LAST_NEWLINE = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tdata,
    input  logic       i_tlast,
    input  logic       i_tvalid,
    output logic       o_tready,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("stream_uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_NL
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             last_q, last_d;
    logic             tready_q, tready_d;
    logic             tx_q, tx_d;
    logic             bit_done;

    assign bit_done = (cnt_q == '0);

    // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        last_d    = last_q;
        tready_d  = tready_q;
        tx_d      = tx_q;

        unique case (state_q)
            S_IDLE: begin
                tready_d = 1'b1;
                tx_d     = 1'b1;
                if (i_tvalid && tready_q) begin
                    state_d  = S_START;
                    shift_d  = i_tdata;
                    last_d   = i_tlast;
                    tready_d = 1'b0;
                    tx_d     = 1'b0;
                    cnt_d    = CNT_RELOAD;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = '0;
                    cnt_d     = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    // The line stays high through the stop bit into IDLE or NL.
                    if ((LAST_NEWLINE != 0) && last_q) begin
                        state_d = S_NL;
                    end else begin
                        state_d  = S_IDLE;
                        tready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_NL: begin
                state_d = S_START;
                shift_d = 8'h0A;
                last_d  = 1'b0;
                tx_d    = 1'b0;
                cnt_d   = CNT_RELOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            last_q    <= 1'b0;
            tready_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            last_q    <= last_d;
            tready_q  <= tready_d;
            tx_q      <= tx_d;
        end
    end

    assign o_tready  = tready_q;
    assign o_uart_tx = tx_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_stream_uart_tx.sv
// Bench for stream_uart_tx: two instances (newline off/on) at 4 clocks per bit.
// A line receiver per instance decodes frames and checks them against queued expectations.
module tb_stream_uart_tx;

    localparam int C      = 4;
    localparam int BUDGET = 600;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0][7:0] tdata = '0;
    logic [1:0]      tlast = '0;
    logic [1:0]      tvalid = '0;
    logic            tready0, tready1, line0, line1, busy0, busy1;
    logic [1:0]      tready, line, busy;
    int              cyc = 0;
    int              total = 0;
    int              bad = 0;
    logic [7:0]      exp0[$];
    logic [7:0]      exp1[$];

    assign tready = {tready1, tready0};
    assign line   = {line1, line0};
    assign busy   = {busy1, busy0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_uart_tx #(.CLK_FREQ_HZ(460800), .BAUD_RATE(115200), .LAST_NEWLINE(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[0]), .i_tlast(tlast[0]),
        .i_tvalid(tvalid[0]), .o_tready(tready0), .o_uart_tx(line0), .o_busy(busy0)
    );

    stream_uart_tx #(.CLK_FREQ_HZ(460800), .BAUD_RATE(115200), .LAST_NEWLINE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata[1]), .i_tlast(tlast[1]),
        .i_tvalid(tvalid[1]), .o_tready(tready1), .o_uart_tx(line1), .o_busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a byte at a negedge and wait for it to be taken; returns at the
    // negedge following the accepting edge with tvalid still asserted.
    task automatic send(input int k, input logic [7:0] d, input logic l, output int t);
        int n = 0;
        tdata[k]  = d;
        tlast[k]  = l;
        tvalid[k] = 1'b1;
        while (!tready[k] && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_in_time%0d", k), 32'(n < BUDGET), 1);
        @(negedge clk);
        t = cyc;
        if (k == 0) begin
            exp0.push_back(d);
        end else begin
            exp1.push_back(d);
            if (l) exp1.push_back(8'h0A);
        end
        check($sformatf("busy_after_accept%0d", k), 32'(busy[k]), 1);
        check($sformatf("tready_after_accept%0d", k), 32'(tready[k]), 0);
    endtask

    task automatic count_low(input int k, output int n);
        n = 0;
        while (!tready[k] && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Receiver: samples once per cycle, requires each bit to hold exactly C cycles.
    task automatic monitor(input int k);
        logic [9:0] bits;
        logic       shape_ok;
        logic       aborted;
        logic       have;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && line[k] == 1'b0) begin
                shape_ok = 1'b1;
                aborted  = 1'b0;
                bits     = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < C; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) bits[b] = line[k];
                        else if (line[k] !== bits[b]) shape_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    check($sformatf("bit_hold%0d", k), 32'(shape_ok), 1);
                    check($sformatf("stop_bit%0d", k), 32'(bits[9]), 1);
                    e = 8'h00;
                    if (k == 0) begin
                        have = (exp0.size() > 0);
                        if (have) e = exp0.pop_front();
                    end else begin
                        have = (exp1.size() > 0);
                        if (have) e = exp1.pop_front();
                    end
                    check($sformatf("frame_expected%0d", k), 32'(have), 1);
                    if (have) check($sformatf("frame_data%0d", k), 32'(bits[8:1]), 32'(e));
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, n, k, gap;
        logic [7:0] d;
        logic l;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_tx%0d", i), 32'(line[i]), 1);
            check($sformatf("rst_tready%0d", i), 32'(tready[i]), 0);
            check($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rel_tready%0d", i), 32'(tready[i]), 1);
            check($sformatf("rel_tx%0d", i), 32'(line[i]), 1);
            check($sformatf("rel_busy%0d", i), 32'(busy[i]), 0);
        end

        // Single byte, then tlast on the newline-free instance.
        send(0, 8'h41, 1'b0, t1);
        tvalid[0] = 1'b0;
        count_low(0, n);
        check("tready_low_41", n, 10 * C);
        send(0, 8'h7E, 1'b1, t1);
        tvalid[0] = 1'b0;
        count_low(0, n);
        check("tready_low_tlast_no_nl", n, 10 * C);

        // Back-to-back with tvalid held.
        send(0, 8'h55, 1'b0, t1);
        send(0, 8'hAA, 1'b0, t2);
        tvalid[0] = 1'b0;
        check("b2b_spacing", t2 - t1, 10 * C + 1);
        count_low(0, n);

        // Newline insertion.
        send(1, 8'h30, 1'b1, t1);
        tvalid[1] = 1'b0;
        count_low(1, n);
        check("tready_low_nl", n, 20 * C + 1);
        send(1, 8'h31, 1'b1, t1);
        send(1, 8'h32, 1'b0, t2);
        tvalid[1] = 1'b0;
        check("b2b_spacing_nl", t2 - t1, 20 * C + 2);
        count_low(1, n);

        // Inputs churn while not ready; only the captured byte goes out.
        send(1, 8'hC3, 1'b0, t1);
        n = 0;
        while (!tready[1] && n < BUDGET) begin
            tvalid[1] = 1'($urandom_range(0, 1));
            tdata[1]  = 8'($urandom);
            tlast[1]  = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        tvalid[1] = 1'b0;
        check("tready_low_churn", n, 10 * C);

        // Reset during data bit 3 of 0xFF.
        send(0, 8'hFF, 1'b0, t1);
        tvalid[0] = 1'b0;
        repeat (4 * C + 1) @(negedge clk);
        check("busy_mid_frame", 32'(busy[0]), 1);
        #1 rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        #1;
        check("async_rst_tx", 32'(line[0]), 1);
        check("async_rst_busy", 32'(busy[0]), 0);
        check("async_rst_tready", 32'(tready[0]), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_tready", 32'(tready[0]), 1);
        check("rerelease_tx", 32'(line[0]), 1);
        send(0, 8'h00, 1'b0, t1);
        tvalid[0] = 1'b0;
        count_low(0, n);
        check("tready_low_after_rst", n, 10 * C);

        // Randomized traffic across both instances.
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 1);
            d = 8'($urandom);
            l = 1'($urandom_range(0, 1));
            send(k, d, l, t1);
            tvalid[k] = 1'b0;
            count_low(k, n);
            check($sformatf("rand_tready_low%0d", i), n, (k == 1 && l) ? 20 * C + 1 : 10 * C);
            gap = $urandom_range(0, 6);
            repeat (gap) @(negedge clk);
        end

        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("pending_frames0", exp0.size(), 0);
        check("pending_frames1", exp1.size(), 0);
        check("final_idle_line", 32'(line), 32'h3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_uart_tx.md
STREAM_UART_TX -- requirements
Module: stream_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 16000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 57600, UART bit rate.
REQ-003 The block SHALL have parameter LAST_NEWLINE, default 0; when 1, a 0x0A frame follows every byte accepted with tlast.
REQ-004 The block SHALL have port i_clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port i_tdata, input, 8 bits, stream byte to transmit.
REQ-007 The block SHALL have port i_tlast, input, 1 bit, end-of-message marker qualified by i_tvalid.
REQ-008 The block SHALL have port i_tvalid, input, 1 bit, upstream byte valid.
REQ-009 The block SHALL have port o_tready, output, 1 bit, registered, block can accept a byte.
REQ-010 The block SHALL have port o_uart_tx, output, 1 bit, registered serial line, idle high.
REQ-011 The block SHALL have port o_busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-012 CLKS_PER_BIT SHALL be CLK_FREQ_HZ/BAUD_RATE with integer truncation; values below 2 SHALL be a parameter error at elaboration.
REQ-013 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL count down from CLKS_PER_BIT-1 to 0 for every bit.
REQ-014 Each frame SHALL be 8N1: one start bit (0), data bits 0..7 LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-015 A transfer SHALL occur on the rising edge where i_tvalid and o_tready are both 1; i_tdata and i_tlast are captured on that edge.
REQ-016 On a transfer edge, o_tready SHALL go to 0 and o_uart_tx SHALL go to 0 (start bit begins the cycle after the edge).
REQ-017 The state machine SHALL have states IDLE, START, DATA, STOP, NL; IDLE->START on transfer; START->DATA after one bit period; DATA->STOP after the eighth bit period; STOP->IDLE or STOP->NL at the end of the stop bit.
REQ-018 STOP SHALL go to NL only when LAST_NEWLINE=1 and the captured tlast was 1; NL SHALL load 0x0A and re-enter START without asserting o_tready.
REQ-019 On the edge that ends the final stop bit, o_tready SHALL be set to 1 and o_uart_tx SHALL remain 1.
REQ-020 Minimum byte-to-byte transfer spacing SHALL be 10*CLKS_PER_BIT+1 cycles; 20*CLKS_PER_BIT+2 when a newline frame is inserted.
REQ-021 i_tdata, i_tlast and i_tvalid SHALL be ignored while o_tready is 0; a held i_tvalid SHALL be accepted on the first edge at which o_tready is 1.
REQ-022 i_tlast=1 with LAST_NEWLINE=0 SHALL have no effect on the serial output.
REQ-023 o_busy SHALL be 1 from the cycle after a transfer until o_tready returns to 1.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately set state to IDLE, o_uart_tx=1, o_tready=0, o_busy=0, counters=0 and the shift register to 0, without waiting for a clock edge.
REQ-025 Reset asserted mid-frame SHALL abort the frame; no partial frame SHALL resume after reset release.
REQ-026 o_tready SHALL go to 1 on the first rising edge after i_rst_n goes high.

Verification
REQ-027 Reset release with CLK_FREQ_HZ=460800, BAUD_RATE=115200 (CLKS_PER_BIT=4) -> o_uart_tx=1, o_tready=1 after one edge, o_busy=0.
REQ-028 Send 0x41 with tlast=0 -> o_uart_tx sequence 0,1,0,0,0,0,0,1,0,1, each level held 4 cycles; o_tready=1 after 40 cycles.
REQ-029 Back-to-back 0x55, 0xAA with i_tvalid held high -> second transfer exactly 41 cycles after the first; line shows both frames with one extra idle-high cycle between them.
REQ-030 LAST_NEWLINE=1, send 0x30 with tlast=1 -> frame 0x30 then frame 0x0A; o_tready stays 0 for 81 cycles.
REQ-031 Assert i_rst_n low during data bit 3 of 0xFF -> o_uart_tx=1 in the same cycle, o_busy=0; after release, send 0x00 -> a clean frame of 0x00.
REQ-032 i_tvalid toggled with changing i_tdata while o_tready=0 -> transmitted frame equals the captured byte and is unaffected by the changes.
